// File: rtl/image_window_gen.sv
// image_window_gen: raster pixel stream in, every 2x2 sliding window out as {TL,TR,BL,BR}.
// Optional WINDOW_BIPOLAR_CHECK_EN builds a sticky detector for non-bipolar pixels on pix_err.
module image_window_gen #(
   parameter int IMG_W = 3,
   parameter int IMG_H = 3,
   parameter int PIX_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [PIX_W-1:0]   pix_in,
   input  logic               pix_valid,
   input  logic               pix_sof,
   output logic               pix_ready,
   output logic [4*PIX_W-1:0] pixels,
   output logic               win_valid,
   input  logic               win_ready,
   output logic               win_last,
   output logic               frame_err,
   output logic               pix_err
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [PIX_W-1:0] sr_reg [IMG_W+1];
   logic [CW-1:0]    col_reg, col_eff, col_next;
   logic [RW-1:0]    row_reg, row_eff, row_next;
   logic             accept, at_last, emit;

   assign pix_ready = !win_valid || win_ready;
   assign accept    = pix_valid && pix_ready;

   // SOF pins the current pixel to (0,0); everything downstream uses the effective position.
   assign col_eff = pix_sof ? '0 : col_reg;
   assign row_eff = pix_sof ? '0 : row_reg;
   assign at_last = (col_eff == COL_LAST) && (row_eff == ROW_LAST);
   assign emit    = accept && (row_eff != '0) && (col_eff != '0);

   always_comb begin
      col_next = col_eff + 1'b1;
      row_next = row_eff;
      if (col_eff == COL_LAST) begin
         col_next = '0;
         row_next = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end
   end

   // One row plus one pixel of history: sr[0] is the left neighbour, sr[IMG_W] the up-left one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i <= IMG_W; i++) sr_reg[i] <= '0;
      end else if (accept) begin
         sr_reg[0] <= pix_in;
         for (int i = 1; i <= IMG_W; i++) sr_reg[i] <= sr_reg[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_reg   <= '0;
         row_reg   <= '0;
         frame_err <= 1'b0;
      end else if (accept) begin
         col_reg <= col_next;
         row_reg <= row_next;
         if (pix_sof && ((col_reg != '0) || (row_reg != '0))) frame_err <= 1'b1;
      end
   end

   // Single output stage; a new window may replace the one being taken in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pixels    <= '0;
         win_valid <= 1'b0;
         win_last  <= 1'b0;
      end else if (emit) begin
         pixels    <= {sr_reg[IMG_W], sr_reg[IMG_W-1], sr_reg[0], pix_in};
         win_valid <= 1'b1;
         win_last  <= at_last;
      end else if (win_ready) begin
         win_valid <= 1'b0;
         win_last  <= 1'b0;
      end
   end

`ifdef WINDOW_BIPOLAR_CHECK_EN
   localparam logic [PIX_W-1:0] POS_ONE = PIX_W'(1);
   localparam logic [PIX_W-1:0] NEG_ONE = '1;
   logic pix_err_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pix_err_reg <= 1'b0;
      end else if (accept && (pix_in != POS_ONE) && (pix_in != NEG_ONE)) begin
         pix_err_reg <= 1'b1;
      end
   end

   assign pix_err = pix_err_reg;
`else
   assign pix_err = 1'b0;
`endif

endmodule

// File: tb/tb_image_window_gen.sv
// Testbench for image_window_gen: vector table, hand-written corner sequences, and random
// traffic checked against an image-array scoreboard.
`timescale 1ns/1ps
module tb_image_window_gen;
   localparam int W = 3;
   localparam int H = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  pix_in = '0;
   logic        pix_valid = 1'b0;
   logic        pix_sof = 1'b0;
   logic        pix_ready;
   logic [31:0] pixels;
   logic        win_valid;
   logic        win_ready = 1'b1;
   logic        win_last;
   logic        frame_err;
   logic        pix_err;

   always #5 clk = ~clk;

   image_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
      .pix_ready(pix_ready), .pixels(pixels), .win_valid(win_valid), .win_ready(win_ready),
      .win_last(win_last), .frame_err(frame_err), .pix_err(pix_err)
   );

   typedef struct {
      logic [7:0]  pix;
      logic        sof;
      logic        emit;
      logic        last;
      logic [31:0] win;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int n_win = 0;

   // Frames: X, O, "/" ; and "\" used after the mid-frame reset.
   logic [7:0]  fpix [3][9] = '{
      '{8'h01, 8'hff, 8'h01, 8'hff, 8'h01, 8'hff, 8'h01, 8'hff, 8'h01},
      '{8'hff, 8'h01, 8'hff, 8'h01, 8'hff, 8'h01, 8'hff, 8'h01, 8'hff},
      '{8'hff, 8'hff, 8'h01, 8'hff, 8'h01, 8'hff, 8'h01, 8'hff, 8'hff}};
   logic [31:0] fwin [3][4] = '{
      '{32'h01ffff01, 32'hff0101ff, 32'hff0101ff, 32'h01ffff01},
      '{32'hff0101ff, 32'h01ffff01, 32'h01ffff01, 32'hff0101ff},
      '{32'hffffff01, 32'hff0101ff, 32'hff0101ff, 32'h01ffffff}};
   logic [7:0]  bs_pix [9] = '{8'h01, 8'hff, 8'hff, 8'hff, 8'h01, 8'hff, 8'hff, 8'hff, 8'h01};
   logic [31:0] bs_win [4] = '{32'h01ffff01, 32'hffff01ff, 32'hff01ffff, 32'h01ffff01};
   vec_t        vecs [27];

   // Reference model: the frame as a 2D image; each window is read straight from it.
   logic [32:0] exp_q [$];
   logic [7:0]  img [H][W];
   int          m_row = 0;
   int          m_col = 0;
   logic        m_ferr = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic int win_idx(input int k);
      case (k)
         4: return 0;
         5: return 1;
         7: return 2;
         8: return 3;
         default: return -1;
      endcase
   endfunction

   always @(negedge clk) begin : monitor
      logic [32:0] e;
      int r, c;
      if (!rst) begin
         exp_q.delete();
         m_row = 0;
         m_col = 0;
         m_ferr = 1'b0;
      end else begin
         if (win_valid && win_ready) begin
            n_win++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL win_unexpected: got %h last=%0b, required no window", pixels, win_last);
            end else begin
               e = exp_q.pop_front();
               check("win", {31'b0, pixels, win_last}, {31'b0, e});
            end
         end
         if (pix_valid && pix_ready) begin
            if (pix_sof && (m_row != 0 || m_col != 0)) m_ferr = 1'b1;
            r = pix_sof ? 0 : m_row;
            c = pix_sof ? 0 : m_col;
            img[r][c] = pix_in;
            if (r >= 1 && c >= 1)
               exp_q.push_back({img[r-1][c-1], img[r-1][c], img[r][c-1], pix_in,
                                (r == H-1 && c == W-1)});
            if (c == W-1) begin
               m_col = 0;
               m_row = (r == H-1) ? 0 : r + 1;
            end else begin
               m_col = c + 1;
               m_row = r;
            end
         end
      end
   end

   task automatic idle(input int n);
      pix_valid = 1'b0;
      pix_sof = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one pixel and return #1 after the edge that accepted it.
   task automatic send(input logic [7:0] p, input logic s);
      int waitc = 0;
      pix_in = p;
      pix_sof = s;
      pix_valid = 1'b1;
      @(negedge clk);
      while (!pix_ready && waitc < 50) begin
         waitc++;
         @(negedge clk);
      end
      if (!pix_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: got pix_ready=0 for 50 cycles, required 1");
      end
      @(posedge clk);
      #1;
      pix_valid = 1'b0;
      pix_sof = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200us, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int wi;

      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 9; k++) begin
            wi = win_idx(k);
            vecs[f*9+k].pix  = fpix[f][k];
            vecs[f*9+k].sof  = (k == 0);
            vecs[f*9+k].emit = (wi >= 0);
            vecs[f*9+k].last = (k == 8);
            vecs[f*9+k].win  = 32'h0;
            if (wi >= 0) vecs[f*9+k].win = fwin[f][wi];
         end
      end

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_pixels", pixels, 32'h0);
      check("rst_win_valid", win_valid, 1'b0);
      check("rst_win_last", win_last, 1'b0);
      check("rst_frame_err", frame_err, 1'b0);
      check("rst_pix_err", pix_err, 1'b0);
      check("rst_pix_ready", pix_ready, 1'b1);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // X, O, "/" back-to-back at full rate: window one cycle after its BR pixel
      for (int i = 0; i < 27; i++) begin
         pix_in = vecs[i].pix;
         pix_sof = vecs[i].sof;
         pix_valid = 1'b1;
         @(posedge clk);
         #1;
         check("tbl_valid", win_valid, vecs[i].emit);
         if (vecs[i].emit) begin
            check("tbl_pixels", pixels, vecs[i].win);
            check("tbl_last", win_last, vecs[i].last);
         end
      end
      idle(3);
      check("tbl_drain", exp_q.size(), 0);

      // Back-pressure on the first window of an X frame
      base = n_win;
      for (int k = 0; k < 5; k++) send(fpix[0][k], k == 0);
      win_ready = 1'b0;
      check("hold_valid0", win_valid, 1'b1);
      check("hold_pixels0", pixels, 32'h01ffff01);
      pix_in = fpix[0][5];
      pix_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("hold_pixels", pixels, 32'h01ffff01);
         check("hold_valid", win_valid, 1'b1);
         check("hold_ready", pix_ready, 1'b0);
      end
      win_ready = 1'b1;
      for (int k = 5; k < 9; k++) send(fpix[0][k], 1'b0);
      idle(3);
      check("hold_count", n_win - base, 4);
      check("hold_drain", exp_q.size(), 0);

      // SOF on the 5th pixel of a frame, followed by an O frame
      for (int k = 0; k < 4; k++) send($urandom_range(0, 1) ? 8'h01 : 8'hff, k == 0);
      check("ferr_pre", frame_err, 1'b0);
      base = n_win;
      send(fpix[1][0], 1'b1);
      check("ferr_set", frame_err, 1'b1);
      for (int k = 1; k < 9; k++) send(fpix[1][k], 1'b0);
      idle(3);
      check("ferr_count", n_win - base, 4);
      check("ferr_drain", exp_q.size(), 0);

      // Reset mid-frame with a window pending, then "\" frame without SOF
      for (int k = 0; k < 5; k++) send(bs_pix[k], k == 0);
      check("mrst_pending", win_valid, 1'b1);
      win_ready = 1'b0;
      rst = 1'b0;
      #1;
      check("mrst_pixels", pixels, 32'h0);
      check("mrst_valid", win_valid, 1'b0);
      check("mrst_last", win_last, 1'b0);
      check("mrst_frame_err", frame_err, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      win_ready = 1'b1;
      base = n_win;
      for (int k = 0; k < 9; k++) begin
         send(bs_pix[k], 1'b0);
         wi = win_idx(k);
         check("bs_valid", win_valid, wi >= 0);
         if (wi >= 0) check("bs_pixels", pixels, bs_win[wi]);
      end
      idle(3);
      check("bs_count", n_win - base, 4);
      check("bs_drain", exp_q.size(), 0);

      // Random traffic: gaps, back-pressure, occasional stray SOF
      for (int i = 0; i < 1500; i++) begin
         pix_valid = ($urandom_range(0, 9) < 7);
         pix_in = $urandom_range(0, 1) ? 8'h01 : 8'hff;
         pix_sof = ($urandom_range(0, 29) == 0);
         win_ready = ($urandom_range(0, 9) < 7);
         @(posedge clk);
         #1;
      end
      win_ready = 1'b1;
      idle(5);
      check("rand_drain", exp_q.size(), 0);
      check("rand_frame_err", frame_err, m_ferr);
      check("rand_pix_err", pix_err, 1'b0);

      // Non-bipolar pixel at (1,1)
      for (int k = 0; k < 9; k++) begin
         send((k == 4) ? 8'h00 : fpix[0][k], k == 0);
         if (k == 4) check("perr_win_br", pixels[7:0], 8'h00);
      end
`ifdef WINDOW_BIPOLAR_CHECK_EN
      check("perr_flag", pix_err, 1'b1);
`else
      check("perr_flag", pix_err, 1'b0);
`endif
      idle(3);
      check("perr_drain", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
